// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared types and defaults for the instruction-fetch unit.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned FETCH_DATA_WIDTH = 32;
    localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] FETCH_NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    // PC update selector: keep, advance one word, or load a redirect target
    typedef enum logic [1:0] {
        PC_KEEP = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_op_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_register.sv
`default_nettype none
// ============================================================================
//  Module   : pc_register
//  Brief    : Program counter with keep / increment / word-aligned load.
//  Revision : 1.0  initial release
// ============================================================================
module pc_register
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(FETCH_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  pc_op_t                pc_op_i,
    input  logic [DATA_WIDTH-1:0] target_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o
);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;

    assign pc_plus4_o = pc_q + DATA_WIDTH'(4);
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = pc_q;
        unique case (pc_op_i)
            PC_INC:  pc_d = pc_plus4_o;
            // Targets are forced onto a word boundary
            PC_LOAD: pc_d = target_i & ~DATA_WIDTH'(3);
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : IF-stage producer: PC ownership, single-outstanding imem fetch,
//             stall hold buffer, execute redirect and NOP bubble insertion.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(FETCH_RESET_PC),
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(FETCH_NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instrF,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic                  validF
);

    fetch_state_t          state_q;
    fetch_state_t          state_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] hold_d;
    pc_op_t                pc_op_d;
    logic                  req_d;
    logic                  valid_d;
    logic                  use_hold_d;
    logic [DATA_WIDTH-1:0] pc_w;

    pc_register #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_op_i    (pc_op_d),
        .target_i   (PCTargetE),
        .pc_o       (pc_w),
        .pc_plus4_o (PCPlus4F)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            hold_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Redirect is evaluated first in every state so it always beats StallF
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pc_op_d    = PC_KEEP;
        req_d      = 1'b0;
        valid_d    = 1'b0;
        use_hold_d = 1'b0;
        unique case (state_q)
            S_REQ: begin
                req_d = 1'b1;
                if (PCSrcE) begin
                    pc_op_d = PC_LOAD;
                    // A request granted alongside a redirect returns stale data
                    state_d = imem_gnt ? S_DROP : S_REQ;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    pc_op_d = PC_LOAD;
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    if (StallF) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        valid_d = 1'b1;
                        pc_op_d = PC_INC;
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                valid_d    = 1'b1;
                use_hold_d = 1'b1;
                if (PCSrcE) begin
                    pc_op_d = PC_LOAD;
                    state_d = S_REQ;
                end else if (!StallF) begin
                    pc_op_d = PC_INC;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (PCSrcE) begin
                    pc_op_d = PC_LOAD;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Outputs are masked combinationally so nothing escapes during reset
    assign imem_req  = rst_n & req_d;
    assign validF    = rst_n & valid_d;
    assign imem_addr = pc_w;
    assign PCF       = pc_w;
    assign instrF    = !validF    ? NOP_INSTR :
                       use_hold_d ? hold_q    : imem_rdata;

endmodule
`default_nettype wire
